// File: rtl/regfile_scoreboard.sv
// MIPS architectural register file with write-through bypassed read ports and a
// per-register pending-writer scoreboard that drives the decode stall.
module regfile_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic        RsUsedD,
    input  logic        RtUsedD,
    input  logic        IssueD,
    input  logic [4:0]  IssueRegD,
    input  logic        KillE,
    input  logic [4:0]  KillRegE,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic        BusyRsD,
    output logic        BusyRtD,
    output logic        StallD,
    output logic        ErrSB
);

    logic [31:0] rf_q  [1:31];
    logic [1:0]  cnt_q [1:31];
    logic [1:0]  cnt_d [1:31];
    logic [2:0]  step  [1:31];
    logic        err_q, err_d;

    logic [31:0] rf_rs, rf_rt;
    logic [1:0]  cnt_rs, cnt_rt;
    logic        wb_rs, wb_rt;

    // Returns {saturated, next count}; the 4-bit sum covers -2..4.
    function automatic logic [2:0] step_cnt(input logic [1:0] c, input logic inc,
                                            input logic dw, input logic dk);
        logic [3:0] n;
        n = {2'b00, c} + {3'b000, inc} - {3'b000, dw} - {3'b000, dk};
        if (n[3])
            step_cnt = 3'b100;
        else if (n[2])
            step_cnt = 3'b111;
        else
            step_cnt = {1'b0, n[1:0]};
    endfunction

    always_comb begin
        err_d = err_q;
        for (int unsigned r = 1; r < 32; r++) begin
            step[r]  = step_cnt(cnt_q[r],
                                IssueD    && (IssueRegD == 5'(r)),
                                RegWriteW && (WriteRegW == 5'(r)),
                                KillE     && (KillRegE  == 5'(r)));
            cnt_d[r] = step[r][1:0];
            if (step[r][2])
                err_d = 1'b1;
        end
    end

    always_comb begin
        rf_rs  = '0;
        rf_rt  = '0;
        cnt_rs = '0;
        cnt_rt = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            if (RsD == 5'(r)) begin
                rf_rs  = rf_q[r];
                cnt_rs = cnt_q[r];
            end
            if (RtD == 5'(r)) begin
                rf_rt  = rf_q[r];
                cnt_rt = cnt_q[r];
            end
        end
    end

    always_comb begin
        wb_rs = RegWriteW && (WriteRegW == RsD) && (RsD != 5'd0);
        wb_rt = RegWriteW && (WriteRegW == RtD) && (RtD != 5'd0);

        if (rst || RsD == 5'd0) RD1D = '0;
        else if (wb_rs)         RD1D = ResultW;
        else                    RD1D = rf_rs;

        if (rst || RtD == 5'd0) RD2D = '0;
        else if (wb_rt)         RD2D = ResultW;
        else                    RD2D = rf_rt;

        // A same-cycle writeback retires one pending writer; kills are not credited.
        BusyRsD = !rst && (RsD != 5'd0) && (cnt_rs != 2'd0) && !(cnt_rs == 2'd1 && wb_rs);
        BusyRtD = !rst && (RtD != 5'd0) && (cnt_rt != 2'd0) && !(cnt_rt == 2'd1 && wb_rt);
        StallD  = (RsUsedD && BusyRsD) || (RtUsedD && BusyRtD);
        ErrSB   = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 1; r < 32; r++) begin
                rf_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < 32; r++) begin
                if (RegWriteW && (WriteRegW == 5'(r)))
                    rf_q[r] <= ResultW;
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed-vector bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteW = 1'b0;
    logic [4:0]  WriteRegW = '0;
    logic [31:0] ResultW = '0;
    logic [4:0]  RsD = '0, RtD = '0;
    logic        RsUsedD = 1'b0, RtUsedD = 1'b0;
    logic        IssueD = 1'b0;
    logic [4:0]  IssueRegD = '0;
    logic        KillE = 1'b0;
    logic [4:0]  KillRegE = '0;
    logic [31:0] RD1D, RD2D;
    logic        BusyRsD, BusyRtD, StallD, ErrSB;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .RsD(RsD), .RtD(RtD), .RsUsedD(RsUsedD), .RtUsedD(RtUsedD),
        .IssueD(IssueD), .IssueRegD(IssueRegD),
        .KillE(KillE), .KillRegE(KillRegE),
        .RD1D(RD1D), .RD2D(RD2D),
        .BusyRsD(BusyRsD), .BusyRtD(BusyRtD), .StallD(StallD), .ErrSB(ErrSB)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rst, we;
        logic [4:0]  wreg;
        logic [31:0] wd;
        logic [4:0]  rs, rt;
        logic        rsu, rtu, iss;
        logic [4:0]  ireg;
        logic        kill;
        logic [4:0]  kreg;
        logic [31:0] e1, e2;
        logic        eb1, eb2, est, eer;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] e1, e2;
        logic        eb1, eb2, est, eer;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic vec_t v(string nm, logic r, logic we, logic [4:0] wreg, logic [31:0] wd,
                               logic [4:0] rs, logic [4:0] rt, logic rsu, logic rtu,
                               logic iss, logic [4:0] ireg, logic kill, logic [4:0] kreg,
                               logic [31:0] e1, logic [31:0] e2,
                               logic eb1, logic eb2, logic est, logic eer);
        vec_t t;
        t.nm = nm; t.rst = r; t.we = we; t.wreg = wreg; t.wd = wd;
        t.rs = rs; t.rt = rt; t.rsu = rsu; t.rtu = rtu;
        t.iss = iss; t.ireg = ireg; t.kill = kill; t.kreg = kreg;
        t.e1 = e1; t.e2 = e2; t.eb1 = eb1; t.eb2 = eb2; t.est = est; t.eer = eer;
        return t;
    endfunction

    task automatic chk32(string nm, string f, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s got=%08h want=%08h", nm, f, act, exp);
        end
    endtask

    task automatic chk1(string nm, string f, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s got=%b want=%b", nm, f, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a sample at negedge.
    always @(negedge clk) begin
        while (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk32(e.nm, "RD1D", RD1D, e.e1);
            chk32(e.nm, "RD2D", RD2D, e.e2);
            chk1(e.nm, "BusyRsD", BusyRsD, e.eb1);
            chk1(e.nm, "BusyRtD", BusyRtD, e.eb2);
            chk1(e.nm, "StallD", StallD, e.est);
            chk1(e.nm, "ErrSB", ErrSB, e.eer);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        //                 name    rst we wreg wdata         rs  rt  rsu rtu iss ireg kl kreg  RD1D          RD2D          b1 b2 st er
        vecs.push_back(v("rst_hold", 1, 1, 5, 32'h00001234,  5,  5, 1, 0, 1,  5, 0,  0, 32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(v("rst_rd",   0, 0, 0, 32'h0,         5,  0, 0, 0, 0,  0, 0,  0, 32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(v("iss8",     0, 0, 0, 32'h0,         8,  0, 1, 0, 1,  8, 0,  0, 32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(v("byp8",     0, 1, 8, 32'hDEADBEEF,  8,  8, 1, 1, 0,  0, 0,  0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(v("rd8",      0, 0, 0, 32'h0,         8,  0, 0, 0, 0,  0, 0,  0, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0));
        vecs.push_back(v("wr0",      0, 1, 0, 32'hCAFEF00D,  0,  8, 0, 0, 0,  0, 0,  0, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(v("rd0",      0, 0, 0, 32'h0,         0,  0, 0, 0, 0,  0, 0,  0, 32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(v("iss9",     0, 0, 0, 32'h0,         9,  0, 1, 0, 1,  9, 0,  0, 32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(v("raw9a",    0, 0, 0, 32'h0,         9,  0, 1, 0, 0,  0, 0,  0, 32'h0,        32'h0,        1, 0, 1, 0));
        vecs.push_back(v("raw9b",    0, 0, 0, 32'h0,         9,  0, 1, 0, 0,  0, 0,  0, 32'h0,        32'h0,        1, 0, 1, 0));
        vecs.push_back(v("unused9",  0, 0, 0, 32'h0,         9,  9, 0, 0, 0,  0, 0,  0, 32'h0,        32'h0,        1, 1, 0, 0));
        vecs.push_back(v("wb9",      0, 1, 9, 32'h0BADF00D,  9,  0, 1, 0, 0,  0, 0,  0, 32'h0BADF00D, 32'h0,        0, 0, 0, 0));
        vecs.push_back(v("post9",    0, 0, 0, 32'h0,         9,  0, 1, 0, 0,  0, 0,  0, 32'h0BADF00D, 32'h0,        0, 0, 0, 0));
        vecs.push_back(v("iss12",    0, 0, 0, 32'h0,         0, 12, 0, 1, 1, 12, 0,  0, 32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(v("kill12",   0, 0, 0, 32'h0,         0, 12, 0, 1, 0,  0, 1, 12, 32'h0,        32'h0,        0, 1, 1, 0));
        vecs.push_back(v("post12",   0, 0, 0, 32'h0,        12, 12, 1, 1, 0,  0, 0,  0, 32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(v("jal1",     0, 0, 0, 32'h0,        31,  0, 0, 0, 1, 31, 0,  0, 32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(v("jal2",     0, 0, 0, 32'h0,        31,  0, 0, 0, 1, 31, 0,  0, 32'h0,        32'h0,        1, 0, 0, 0));
        vecs.push_back(v("wb31a",    0, 1,31, 32'h11111111, 31,  0, 1, 0, 0,  0, 0,  0, 32'h11111111, 32'h0,        1, 0, 1, 0));
        vecs.push_back(v("mid31",    0, 0, 0, 32'h0,        31,  0, 1, 0, 0,  0, 0,  0, 32'h11111111, 32'h0,        1, 0, 1, 0));
        vecs.push_back(v("wb31b",    0, 1,31, 32'h22222222, 31,  0, 1, 0, 0,  0, 0,  0, 32'h22222222, 32'h0,        0, 0, 0, 0));
        vecs.push_back(v("post31",   0, 0, 0, 32'h0,        31,  0, 1, 0, 0,  0, 0,  0, 32'h22222222, 32'h0,        0, 0, 0, 0));
        vecs.push_back(v("iss20",    0, 0, 0, 32'h0,         0,  0, 0, 0, 1, 20, 0,  0, 32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(v("isswb20",  0, 1,20, 32'h20202020, 20, 20, 0, 0, 1, 20, 0,  0, 32'h20202020, 32'h20202020, 0, 0, 0, 0));
        vecs.push_back(v("hold20",   0, 0, 0, 32'h0,        20,  0, 0, 0, 0,  0, 0,  0, 32'h20202020, 32'h0,        1, 0, 0, 0));
        vecs.push_back(v("iwk20",    0, 1,20, 32'h30303030, 20,  0, 0, 0, 1, 20, 1, 20, 32'h30303030, 32'h0,        0, 0, 0, 0));
        vecs.push_back(v("post20",   0, 0, 0, 32'h0,        20,  0, 1, 0, 0,  0, 0,  0, 32'h30303030, 32'h0,        0, 0, 0, 0));
        vecs.push_back(v("unflow4",  0, 1, 4, 32'h00000044,  4,  0, 0, 0, 0,  0, 0,  0, 32'h00000044, 32'h0,        0, 0, 0, 0));
        vecs.push_back(v("err4",     0, 0, 0, 32'h0,         4,  0, 0, 0, 0,  0, 0,  0, 32'h00000044, 32'h0,        0, 0, 0, 1));
        vecs.push_back(v("sat4a",    0, 0, 0, 32'h0,         4,  0, 0, 0, 1,  4, 0,  0, 32'h00000044, 32'h0,        0, 0, 0, 1));
        vecs.push_back(v("sat4b",    0, 0, 0, 32'h0,         4,  0, 0, 0, 1,  4, 0,  0, 32'h00000044, 32'h0,        1, 0, 0, 1));
        vecs.push_back(v("sat4c",    0, 0, 0, 32'h0,         4,  0, 0, 0, 1,  4, 0,  0, 32'h00000044, 32'h0,        1, 0, 0, 1));
        vecs.push_back(v("sat4d",    0, 0, 0, 32'h0,         4,  0, 0, 0, 1,  4, 0,  0, 32'h00000044, 32'h0,        1, 0, 0, 1));
        vecs.push_back(v("sat4chk",  0, 0, 0, 32'h0,         4,  4, 1, 0, 0,  0, 0,  0, 32'h00000044, 32'h00000044, 1, 1, 1, 1));
        vecs.push_back(v("rst_mid",  1, 1, 4, 32'h00000099,  4,  4, 1, 1, 0,  0, 0,  0, 32'h0,        32'h0,        0, 0, 0, 0));
        vecs.push_back(v("post_rst", 0, 0, 0, 32'h0,         4,  4, 1, 1, 0,  0, 0,  0, 32'h0,        32'h0,        0, 0, 0, 0));

        foreach (vecs[i]) begin
            exp_t e;
            @(posedge clk);
            #1;
            rst       = vecs[i].rst;
            RegWriteW = vecs[i].we;
            WriteRegW = vecs[i].wreg;
            ResultW   = vecs[i].wd;
            RsD       = vecs[i].rs;
            RtD       = vecs[i].rt;
            RsUsedD   = vecs[i].rsu;
            RtUsedD   = vecs[i].rtu;
            IssueD    = vecs[i].iss;
            IssueRegD = vecs[i].ireg;
            KillE     = vecs[i].kill;
            KillRegE  = vecs[i].kreg;
            e.nm  = vecs[i].nm;
            e.e1  = vecs[i].e1;
            e.e2  = vecs[i].e2;
            e.eb1 = vecs[i].eb1;
            e.eb2 = vecs[i].eb2;
            e.est = vecs[i].est;
            e.eer = vecs[i].eer;
            expq.push_back(e);
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want=0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
